// File: rtl/exp6_pkg.sv
// Shared constants and types for the experiment 6 octal storage controller.
// Both the controller and the digit shifter take their defaults from here.
package exp6_pkg;

   localparam int DIGITS = 5;
   localparam int DW     = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } ctrl_state_t;

   typedef logic [DW-1:0] digit_t;

endpackage

// File: rtl/oct_digit_shifter.sv
// Calculator-style entry buffer: new digits enter at position 0 and older ones
// move up, with a digit count that saturates once the buffer is full.
module oct_digit_shifter #(
   parameter int DIGITS = exp6_pkg::DIGITS,
   parameter int DW     = exp6_pkg::DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          shift_en,
   input  logic          clr,
   input  logic [DW-1:0] digit_in,
   output logic [DW-1:0] digits [DIGITS],
   output logic [2:0]    count
);

   localparam logic [2:0] FULL_COUNT = 3'(DIGITS);

   // A shift request on a full buffer is dropped, so the count can never wrap.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int i = 0; i < DIGITS; i++) begin
            digits[i] <= '0;
         end
         count <= '0;
      end else if (shift_en && (count != FULL_COUNT)) begin
         digits[0] <= digit_in;
         for (int i = 1; i < DIGITS; i++) begin
            digits[i] <= digits[i-1];
         end
         count <= count + 3'd1;
      end
   end

endmodule

// File: rtl/oct_entry_ctrl.sv
// Sequencing controller for the 5-digit octal storage register: keypad entry,
// commit (write then read-back), recall-only reads and clears.
module oct_entry_ctrl #(
   parameter int DIGITS = exp6_pkg::DIGITS,
   parameter int DW     = exp6_pkg::DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          digit_valid,
   input  logic [DW-1:0] digit_in,
   input  logic          commit,
   input  logic          recall,
   input  logic          clear,
   output logic [DW-1:0] wr_data_0,
   output logic [DW-1:0] wr_data_1,
   output logic [DW-1:0] wr_data_2,
   output logic [DW-1:0] wr_data_3,
   output logic [DW-1:0] wr_data_4,
   output logic          write_en,
   output logic          read_en,
   output logic          busy,
   output logic [2:0]    count,
   output logic          full
);

   import exp6_pkg::*;

   localparam logic [2:0] FULL_COUNT = 3'(DIGITS);

   ctrl_state_t   state;
   ctrl_state_t   state_next;
   logic          from_commit;
   logic          from_commit_next;
   logic          shift_en;
   logic          clr;
   logic [DW-1:0] digits [DIGITS];

   oct_digit_shifter #(
      .DIGITS (DIGITS),
      .DW     (DW)
   ) u_shifter (
      .clk      (clk),
      .rst      (rst),
      .shift_en (shift_en),
      .clr      (clr),
      .digit_in (digit_in),
      .digits   (digits),
      .count    (count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         from_commit <= 1'b0;
      end else begin
         state       <= state_next;
         from_commit <= from_commit_next;
      end
   end

   // Strobes are only looked at in IDLE; clear beats commit beats recall beats
   // digit entry, and everything arriving during WRITE/READ is simply dropped.
   always_comb begin
      state_next       = state;
      from_commit_next = from_commit;
      shift_en         = 1'b0;
      clr              = 1'b0;
      unique case (state)
         IDLE: begin
            if (clear) begin
               clr = 1'b1;
            end else if (commit) begin
               if (count != 3'd0) begin
                  state_next       = WRITE;
                  from_commit_next = 1'b1;
               end
            end else if (recall) begin
               state_next       = READ;
               from_commit_next = 1'b0;
            end else if (digit_valid) begin
               shift_en = 1'b1;
            end
         end
         WRITE: begin
            state_next = READ;
         end
         READ: begin
            state_next = IDLE;
            // A committed number is consumed once the display has read it back.
            clr        = from_commit;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign write_en  = (state == WRITE);
   assign read_en   = (state == READ);
   assign busy      = (state == WRITE) || (state == READ);
   assign full      = (count == FULL_COUNT);

   assign wr_data_0 = digits[0];
   assign wr_data_1 = digits[1];
   assign wr_data_2 = digits[2];
   assign wr_data_3 = digits[3];
   assign wr_data_4 = digits[4];

endmodule

// File: tb/tb_oct_entry_ctrl.sv
// Self-checking bench for oct_entry_ctrl: directed vector table, a throughput
// sequence, then randomized traffic against a cycle-scheduled reference model.
module tb_oct_entry_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       digit_valid;
   logic [2:0] digit_in;
   logic       commit;
   logic       recall;
   logic       clear;
   logic [2:0] wr_data_0, wr_data_1, wr_data_2, wr_data_3, wr_data_4;
   logic       write_en;
   logic       read_en;
   logic       busy;
   logic [2:0] count;
   logic       full;

   oct_entry_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .digit_valid (digit_valid),
      .digit_in    (digit_in),
      .commit      (commit),
      .recall      (recall),
      .clear       (clear),
      .wr_data_0   (wr_data_0),
      .wr_data_1   (wr_data_1),
      .wr_data_2   (wr_data_2),
      .wr_data_3   (wr_data_3),
      .wr_data_4   (wr_data_4),
      .write_en    (write_en),
      .read_en     (read_en),
      .busy        (busy),
      .count       (count),
      .full        (full)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   // The model tracks the buffer as an octal number plus a digit count, and
   // schedules storage strobes as absolute cycle numbers.
   int mCyc    = 0;
   int mVal    = 0;
   int mCnt    = 0;
   int mWrAt   = -1;
   int mRdAt   = -1;
   int mClrAt  = -1;
   int mFreeAt = 0;

   typedef struct {
      logic        r;
      logic        dv;
      logic [2:0]  d;
      logic        cm;
      logic        rc;
      logic        cl;
      int          cnt;
      logic [14:0] val;
      logic        we;
      logic        re;
      logic        bsy;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, dv, input logic [2:0] d,
                               input logic cm, rc, cl, input int cnt,
                               input logic [14:0] val, input logic we, re, bsy);
      vec_t v;
      v.r = r; v.dv = dv; v.d = d; v.cm = cm; v.rc = rc; v.cl = cl;
      v.cnt = cnt; v.val = val; v.we = we; v.re = re; v.bsy = bsy;
      return v;
   endfunction

   function automatic int bufWord();
      return int'({wr_data_4, wr_data_3, wr_data_2, wr_data_1, wr_data_0});
   endfunction

   task automatic compare(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0o, expected %0o (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic modelEdge(input logic r, dv, input logic [2:0] d,
                            input logic cm, rc, cl);
      int nxt;
      nxt = mCyc + 1;
      if (r) begin
         mVal = 0; mCnt = 0;
         mWrAt = -1; mRdAt = -1; mClrAt = -1; mFreeAt = 0;
      end else if (mCyc >= mFreeAt) begin
         if (cl) begin
            mVal = 0; mCnt = 0;
         end else if (cm) begin
            if (mCnt > 0) begin
               mWrAt = nxt; mRdAt = nxt + 1;
               mClrAt = nxt + 2; mFreeAt = nxt + 2;
            end
         end else if (rc) begin
            mRdAt = nxt; mFreeAt = nxt + 1;
         end else if (dv && mCnt < 5) begin
            mVal = mVal * 8 + int'(d);
            mCnt++;
         end
      end
      if (nxt == mClrAt) begin
         mVal = 0; mCnt = 0;
      end
      mCyc = nxt;
   endtask

   task automatic applyStimulus(input logic r, dv, input logic [2:0] d,
                                input logic cm, rc, cl);
      rst = r; digit_valid = dv; digit_in = d;
      commit = cm; recall = rc; clear = cl;
      @(posedge clk);
      modelEdge(r, dv, d, cm, rc, cl);
      #1;
   endtask

   task automatic checkOutput(input string tag);
      compare({tag, ".data"},  bufWord(),      mVal);
      compare({tag, ".count"}, int'(count),    mCnt);
      compare({tag, ".full"},  int'(full),     int'(mCnt == 5));
      compare({tag, ".wr"},    int'(write_en), int'(mCyc == mWrAt));
      compare({tag, ".rd"},    int'(read_en),  int'(mCyc == mRdAt));
      compare({tag, ".busy"},  int'(busy),     int'(mCyc < mFreeAt));
   endtask

   initial begin
      rst = 1'b1; digit_valid = 1'b0; digit_in = 3'd0;
      commit = 1'b0; recall = 1'b0; clear = 1'b0;

      //               r  dv d     cm rc cl cnt val       we re busy
      tbl.push_back(mk(1, 0, 3'd0, 0, 0, 0, 0, 15'o0,     0, 0, 0));
      tbl.push_back(mk(0, 1, 3'd1, 0, 0, 0, 1, 15'o1,     0, 0, 0));
      tbl.push_back(mk(0, 1, 3'd2, 0, 0, 0, 2, 15'o12,    0, 0, 0));
      tbl.push_back(mk(0, 1, 3'd3, 0, 0, 0, 3, 15'o123,   0, 0, 0));
      tbl.push_back(mk(0, 1, 3'd4, 0, 0, 0, 4, 15'o1234,  0, 0, 0));
      tbl.push_back(mk(0, 1, 3'd5, 0, 0, 0, 5, 15'o12345, 0, 0, 0));
      tbl.push_back(mk(0, 0, 3'd0, 1, 0, 0, 5, 15'o12345, 1, 0, 1));
      tbl.push_back(mk(0, 0, 3'd0, 0, 0, 0, 5, 15'o12345, 0, 1, 1));
      tbl.push_back(mk(0, 0, 3'd0, 0, 0, 0, 0, 15'o0,     0, 0, 0));
      tbl.push_back(mk(0, 1, 3'd7, 0, 0, 0, 1, 15'o7,     0, 0, 0));
      tbl.push_back(mk(0, 1, 3'd6, 0, 0, 0, 2, 15'o76,    0, 0, 0));
      tbl.push_back(mk(0, 1, 3'd5, 0, 0, 0, 3, 15'o765,   0, 0, 0));
      tbl.push_back(mk(0, 1, 3'd4, 0, 0, 0, 4, 15'o7654,  0, 0, 0));
      tbl.push_back(mk(0, 1, 3'd3, 0, 0, 0, 5, 15'o76543, 0, 0, 0));
      tbl.push_back(mk(0, 1, 3'd2, 0, 0, 0, 5, 15'o76543, 0, 0, 0));
      tbl.push_back(mk(0, 0, 3'd0, 0, 0, 1, 0, 15'o0,     0, 0, 0));
      tbl.push_back(mk(0, 0, 3'd0, 1, 0, 0, 0, 15'o0,     0, 0, 0));
      tbl.push_back(mk(0, 0, 3'd0, 0, 0, 0, 0, 15'o0,     0, 0, 0));
      tbl.push_back(mk(0, 1, 3'd6, 0, 0, 0, 1, 15'o6,     0, 0, 0));
      tbl.push_back(mk(0, 0, 3'd0, 0, 1, 0, 1, 15'o6,     0, 1, 1));
      tbl.push_back(mk(0, 0, 3'd0, 0, 0, 0, 1, 15'o6,     0, 0, 0));
      tbl.push_back(mk(0, 1, 3'd1, 0, 0, 0, 2, 15'o61,    0, 0, 0));
      tbl.push_back(mk(0, 1, 3'd3, 1, 0, 1, 0, 15'o0,     0, 0, 0));
      tbl.push_back(mk(0, 0, 3'd0, 0, 0, 0, 0, 15'o0,     0, 0, 0));
      tbl.push_back(mk(0, 1, 3'd2, 0, 0, 0, 1, 15'o2,     0, 0, 0));
      tbl.push_back(mk(0, 0, 3'd0, 1, 0, 0, 1, 15'o2,     1, 0, 1));
      tbl.push_back(mk(0, 1, 3'd5, 0, 1, 0, 1, 15'o2,     0, 1, 1));
      tbl.push_back(mk(0, 0, 3'd0, 0, 0, 0, 0, 15'o0,     0, 0, 0));
      tbl.push_back(mk(0, 0, 3'd0, 0, 0, 0, 0, 15'o0,     0, 0, 0));
      tbl.push_back(mk(0, 1, 3'd4, 0, 0, 0, 1, 15'o4,     0, 0, 0));
      tbl.push_back(mk(0, 0, 3'd0, 1, 0, 0, 1, 15'o4,     1, 0, 1));
      tbl.push_back(mk(1, 0, 3'd0, 0, 0, 0, 0, 15'o0,     0, 0, 0));
      tbl.push_back(mk(0, 0, 3'd0, 0, 0, 0, 0, 15'o0,     0, 0, 0));

      @(negedge clk);
      for (int i = 0; i < tbl.size(); i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         applyStimulus(tbl[i].r, tbl[i].dv, tbl[i].d, tbl[i].cm, tbl[i].rc, tbl[i].cl);
         compare({tag, ".data"},  bufWord(),      int'(tbl[i].val));
         compare({tag, ".count"}, int'(count),    tbl[i].cnt);
         compare({tag, ".full"},  int'(full),     int'(tbl[i].cnt == 5));
         compare({tag, ".wr"},    int'(write_en), int'(tbl[i].we));
         compare({tag, ".rd"},    int'(read_en),  int'(tbl[i].re));
         compare({tag, ".busy"},  int'(busy),     int'(tbl[i].bsy));
         checkOutput({tag, ".model"});
      end

      // Back-to-back: a recall on the first IDLE cycle after a commit completes.
      applyStimulus(0, 1, 3'd3, 0, 0, 0);
      applyStimulus(0, 0, 3'd0, 1, 0, 0);
      compare("thru.write", int'(write_en), 1);
      applyStimulus(0, 0, 3'd0, 0, 0, 0);
      compare("thru.read1", int'(read_en), 1);
      compare("thru.nowr",  int'(write_en), 0);
      applyStimulus(0, 0, 3'd0, 0, 0, 0);
      compare("thru.idle",  int'(busy), 0);
      compare("thru.clr",   bufWord(), 0);
      applyStimulus(0, 0, 3'd0, 0, 1, 0);
      compare("thru.read2", int'(read_en), 1);
      applyStimulus(0, 0, 3'd0, 0, 0, 0);
      compare("thru.done",  int'(busy), 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         logic r, dv, cm, rc, cl;
         logic [2:0] d;
         r  = ($urandom_range(0, 59) == 0);
         dv = ($urandom_range(0, 1) == 1);
         d  = 3'($urandom_range(0, 7));
         cm = ($urandom_range(0, 7) == 0);
         rc = ($urandom_range(0, 9) == 0);
         cl = ($urandom_range(0, 19) == 0);
         applyStimulus(r, dv, d, cm, rc, cl);
         checkOutput($sformatf("rnd%0d", i));
         compared++;
         if (write_en && read_en) begin
            mismatched++;
            $display("[TB] FAIL rnd%0d.overlap: got write_en=1 read_en=1, expected not both", i);
         end
      end

      applyStimulus(0, 0, 3'd0, 0, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/oct_entry_ctrl.md
# oct_entry_ctrl

Sequencing controller for the 5-digit octal storage register used in experiment 6. It collects octal digits one at a time from the keypad decoder into an entry buffer. On commit it drives the buffered number into the storage register with a one-cycle `write_en` pulse, then issues a `read_en` pulse so the display side refreshes. It also services recall-only requests and clears, and reports busy and entry count to the display and status logic.

## Interface
Parameters:
- `DIGITS`, 5, number of octal digits held (fixed at 5 for this experiment)
- `DW`, 3, bits per digit

Ports:
- `clk` in 1: system clock; all state updates on rising edge
- `rst` in 1: reset, synchronous, active-high
- `digit_valid` in 1: one-cycle strobe, `digit_in` is a new digit
- `digit_in` in 3: octal digit 0–7
- `commit` in 1: one-cycle strobe, write the buffer to storage
- `recall` in 1: one-cycle strobe, read storage without writing
- `clear` in 1: one-cycle strobe, discard the entry buffer
- `wr_data_0`..`wr_data_4` out 3 each: storage data inputs; digit 0 is least significant
- `write_en` out 1: storage write strobe
- `read_en` out 1: storage read strobe
- `busy` out 1: high in WRITE or READ
- `count` out 3: digits currently buffered, 0–5
- `full` out 1: `count == 5`

## Operation
- **States:** IDLE, WRITE, READ. Entry happens in IDLE. `count` distinguishes an empty buffer from a partial one.
- **Reset:** state IDLE. All `wr_data_*`, `count`, `write_en`, `read_en`, `busy` and `full` are 0.
- **Input priority, sampled only in IDLE:** `clear` > `commit` > `recall` > `digit_valid`. Only the highest-priority asserted strobe acts; the others are dropped.
- **`clear`:** all `wr_data_*` and `count` go to 0. State stays IDLE. No storage strobes.
- **`digit_valid` with `count < 5`:** calculator-style shift. `wr_data_4` ← `wr_data_3` … `wr_data_1` ← `wr_data_0`, `wr_data_0` ← `digit_in`. `count` increments.
- **`digit_valid` with `count == 5`:** ignored. Buffer and `count` unchanged, `full` stays 1.
- **`commit` with `count > 0`:** IDLE → WRITE.
- **`commit` with `count == 0`:** ignored.
- **`recall`:** IDLE → READ. Buffer untouched.
- **WRITE (one cycle):** `write_en` = 1, `wr_data_*` held stable. Next state READ.
- **READ (one cycle):** `read_en` = 1. Next state IDLE.
  - If READ was entered from WRITE, the buffer and `count` clear to 0 on exit.
  - If READ was entered from `recall`, the buffer is preserved. A 1-bit `from_commit` flag tracks which case applies.
- **In WRITE/READ:** all input strobes are ignored, with no queuing.
- **`rst` mid-operation:** on the next edge, state returns to IDLE and every output clears. `write_en`/`read_en` drop in that same cycle.
- **Output decoding:** `write_en`, `read_en` and `busy` are Moore outputs decoded from state.
- **Arithmetic:** `count` saturates at 5 and never wraps. Digits are 3-bit with no range check, since every 3-bit value is a valid octal digit.

## Timing
- **Digit latency:** `digit_valid` sampled at edge k → buffer and `count` updated after edge k, visible during cycle k+1.
- **Commit latency:** `commit` at edge k →
  - cycle k+1: `write_en` = 1, `busy` = 1
  - cycle k+2: `read_en` = 1, `busy` = 1
  - cycle k+3: IDLE, `count` = 0, `wr_data_*` = 0
- `wr_data_*` is stable from one cycle before `write_en` until `read_en` falls. This meets the level-sensitive storage's setup needs.
- **Recall latency:** `recall` at edge k → `read_en` = 1 during cycle k+1, IDLE in cycle k+2.
- **Strobe width:** exactly one cycle each; `write_en` and `read_en` are never high together.
- **Throughput:** a new command is accepted on the first IDLE cycle after `busy` falls.

## Structure
- **Shared package `exp6_pkg`:**
  - `DIGITS` = 5 and `DW` = 3 constants
  - state enum `ctrl_state_t` {IDLE, WRITE, READ}, 2-bit encoding
  - `digit_t` = logic [2:0]
- **Sub-module `oct_digit_shifter`:** 5×3-bit shift buffer with saturating counter. Ports: `clk`, `rst`, `shift_en`, `clr`, `digit_in`, `digits[0..4]`, `count`. The top level holds the FSM, the priority logic and the `from_commit` flag.

## Test plan
- **Entry and commit:**
  - Stimulus: reset, then digits 1,2,3,4,5, then `commit`.
  - Required: `wr_data_4..0` = 1,2,3,4,5, `full` = 1. `write_en` high for exactly one cycle, `read_en` in the next cycle. `count` = 0 and all `wr_data_*` = 0 afterwards.
- **Saturation:**
  - Stimulus: digits 7,6,5,4,3, then digit 2.
  - Required: buffer stays 7,6,5,4,3, `count` = 5.
- **Empty commit and recall:**
  - Stimulus: `commit` with `count` = 0, then `recall` after entering digit 6.
  - Required: no strobes on the commit. One `read_en` pulse on the recall; `wr_data_0` = 6, `count` = 1 retained.
- **Priority:**
  - Stimulus: `clear` + `commit` + `digit_valid` (3) in the same cycle, with `count` = 2.
  - Required: `count` = 0, no `write_en`, digit not stored.
- **Busy lockout:**
  - Stimulus: `digit_valid` (5) and `recall` during the WRITE cycle.
  - Required: both ignored. Exactly one `write_en` and one `read_en` pulse, and the buffer is cleared to 0.
- **Reset mid-operation:**
  - Stimulus: assert `rst` during the WRITE cycle.
  - Required: on the next edge all outputs are 0 and state is IDLE, with no `read_en` pulse.
